vga_scan: RTL

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_scan.sv
// ============================================================================
// Module   : vga_scan
// Brief    : VGA raster scanner: pixel/line counters, registered rgb and
//            active-low sync outputs. Optional frame counter under the macro
//            VGA_SCAN_FRAME_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_scan #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    input  logic [5:0] color,
    output logic [5:0] rgb,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
`ifdef VGA_SCAN_FRAME_EN
    ,
    output logic [7:0] frame
`endif
);

    localparam logic [9:0] c_H_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_H_DISP     = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP     = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [5:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;

    logic w_x_wrap;
    logic w_y_wrap;
    logic w_display_on;
    logic w_hsync_raw;
    logic w_vsync_raw;
    logic w_origin;

    assign w_x_wrap     = (r_x == c_H_LAST);
    assign w_y_wrap     = (r_y == c_V_LAST);
    assign w_display_on = (r_x < c_H_DISP) && (r_y < c_V_DISP);
    assign w_hsync_raw  = !((r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST));
    assign w_vsync_raw  = !((r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST));
    assign w_origin     = (r_x == 10'd0) && (r_y == 10'd0);

    // Counters advance and outputs register from the pre-edge counter values,
    // so rgb/hsync/vsync/frame_start all lag pix_x/pix_y by exactly one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_rgb         <= 6'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x <= w_x_wrap ? 10'd0 : r_x + 10'd1;
            if (w_x_wrap) begin
                r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
            end
            r_rgb         <= w_display_on ? color : 6'd0;
            r_hsync       <= w_hsync_raw;
            r_vsync       <= w_vsync_raw;
            r_frame_start <= w_origin;
        end
    end

`ifdef VGA_SCAN_FRAME_EN
    logic [7:0] r_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= 8'd0;
        end else if (w_x_wrap && w_y_wrap) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    assign frame = r_frame;
`endif

    assign pix_x       = r_x;
    assign pix_y       = r_y;
    assign rgb         = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire
